// File: rtl/ethlite_tx_ctrl.sv
// -----------------------------------------------------------------------------
// ethlite_tx_ctrl
//
// AXI4-Lite master that pushes one frame through the Ethernet Lite TX ping
// buffer. A length command is accepted, the 32-bit payload words are written
// into the buffer one at a time, then the TX length register and the TX start
// bit are programmed. The control register is then polled until the core
// clears the start bit. The result is reported as a done or err pulse.
//
// Ports
//   clk, rst               system clock (same as s_axi_aclk), async active-low reset
//   cmd_valid/ready/len    frame command, length in bytes
//   s_valid/ready/data     payload words, little-endian (byte 0 in [7:0])
//   busy                   high from command accept until done/err
//   done, err              one-cycle completion pulses
//   err_code               1 = bad length, 2 = AXI response error, 3 = timeout;
//                          held until the next command
//   m_axi_*                AXI4-Lite master (AW, W, B, AR, R channels)
//
// Only a 32-bit data bus is supported. At most one AXI transaction is in
// flight, and the read and write channels are never active together.
// -----------------------------------------------------------------------------
module ethlite_tx_ctrl #(
  parameter int                          P_AXI_ADDR_WIDTH = 13,
  parameter int                          P_AXI_DATA_WIDTH = 32,
  parameter logic [P_AXI_ADDR_WIDTH-1:0] P_TX_BUF_ADDR    = 13'h0000,
  parameter logic [P_AXI_ADDR_WIDTH-1:0] P_TX_LEN_ADDR    = 13'h07F4,
  parameter logic [P_AXI_ADDR_WIDTH-1:0] P_TX_CTRL_ADDR   = 13'h07FC,
  parameter int                          P_MAX_LEN        = 1514,
  parameter int                          P_TIMEOUT        = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [10:0]                   cmd_len,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [31:0]                   s_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [1:0]                    err_code,
  output logic [P_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [P_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [P_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [P_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [P_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int          CNT_W   = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [10:0] MAX_LEN = 11'(P_MAX_LEN);
  localparam logic [1:0]  ERR_LEN = 2'd1;
  localparam logic [1:0]  ERR_AXI = 2'd2;
  localparam logic [1:0]  ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_GET, S_WR, S_RESP, S_POLL_AR, S_POLL_R, S_DONE, S_ERR
  } state_t;

  // Which register the write currently in flight targets.
  typedef enum logic [1:0] {PH_DATA, PH_LEN, PH_CTRL} phase_t;

  state_t           state;
  phase_t           phase;
  logic [10:0]      len_q;
  logic [9:0]       words_q;
  logic [9:0]       word_idx;
  logic [CNT_W-1:0] poll_cnt;
  logic [9:0]       cmd_words;

  // Only the busy bit of the control register matters.
  logic unused_rdata;
  assign unused_rdata = ^m_axi_rdata[P_AXI_DATA_WIDTH-1:1];

  // Round the byte count up to whole 32-bit words.
  assign cmd_words = 10'((12'(cmd_len) + 12'd3) >> 2);

  // NOTE: every register in this block uses non-blocking assignment so that
  // all decisions in a cycle see the values from the previous edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      phase         <= PH_DATA;
      len_q         <= '0;
      words_q       <= '0;
      word_idx      <= '0;
      poll_cnt      <= '0;
      cmd_ready     <= 1'b0;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            len_q     <= cmd_len;
            words_q   <= cmd_words;
            if (cmd_len == 11'd0 || cmd_len > MAX_LEN) begin
              // Rejected without touching the bus; cmd_ready returns after the pulse.
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              err_code <= '0;
              busy     <= 1'b1;
              word_idx <= '0;
              phase    <= PH_DATA;
              s_ready  <= 1'b1;
              state    <= S_GET;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_GET: begin
          if (s_valid) begin
            s_ready       <= 1'b0;
            m_axi_wdata   <= P_AXI_DATA_WIDTH'(s_data);
            m_axi_awaddr  <= P_TX_BUF_ADDR + P_AXI_ADDR_WIDTH'({word_idx, 2'b00});
            m_axi_wstrb   <= '1;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= S_WR;
          end
        end

        // AW and W complete independently; leave once both have handshaked.
        S_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= S_RESP;
          end
        end

        S_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_AXI;
              state    <= S_ERR;
            end else begin
              case (phase)
                PH_DATA: begin
                  if (word_idx + 10'd1 < words_q) begin
                    word_idx <= word_idx + 10'd1;
                    s_ready  <= 1'b1;
                    state    <= S_GET;
                  end else begin
                    phase         <= PH_LEN;
                    m_axi_awaddr  <= P_TX_LEN_ADDR;
                    m_axi_wdata   <= P_AXI_DATA_WIDTH'(len_q);
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    state         <= S_WR;
                  end
                end
                PH_LEN: begin
                  phase         <= PH_CTRL;
                  m_axi_awaddr  <= P_TX_CTRL_ADDR;
                  m_axi_wdata   <= P_AXI_DATA_WIDTH'(1);
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= S_WR;
                end
                default: begin
                  poll_cnt      <= '0;
                  m_axi_araddr  <= P_TX_CTRL_ADDR;
                  m_axi_arvalid <= 1'b1;
                  state         <= S_POLL_AR;
                end
              endcase
            end
          end
        end

        S_POLL_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_POLL_R;
          end
        end

        S_POLL_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_AXI;
              state    <= S_ERR;
            end else if (!m_axi_rdata[0]) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (poll_cnt == CNT_W'(P_TIMEOUT - 1)) begin
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_TMO;
              state    <= S_ERR;
            end else begin
              poll_cnt      <= poll_cnt + 1'b1;
              m_axi_arvalid <= 1'b1;
              state         <= S_POLL_AR;
            end
          end
        end

        // The pulse was raised on entry; drop it and reopen for commands.
        default: begin
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ethlite_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ethlite_tx_ctrl
//
// Directed bench for ethlite_tx_ctrl. An AXI4-Lite slave model answers the
// DUT; every expected bus transaction is queued by the stimulus and popped
// and compared by the slave when the DUT performs it. The timeout limit is
// reduced to 4 so that the timeout path is reachable quickly.
// -----------------------------------------------------------------------------
module tb_ethlite_tx_ctrl;

  localparam int          TIMEOUT   = 4;
  localparam logic [12:0] LEN_ADDR  = 13'h07F4;
  localparam logic [12:0] CTRL_ADDR = 13'h07FC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [10:0] cmd_len = '0;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_data = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [12:0] m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  always #5 clk = ~clk;

  ethlite_tx_ctrl #(.P_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  typedef struct packed {
    logic        is_read;
    logic [12:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  bit   poll_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Slave configuration, written by the stimulus only.
  int          aw_lat    = 0;
  bit          w_early   = 1'b0;
  bit          berr_en   = 1'b0;
  logic [12:0] berr_addr = '0;

  // Monitor counters, written by the monitor only.
  int done_cnt = 0, err_cnt = 0, valid_cyc = 0, aw_cyc = 0, overlap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int f, input int k);
    return {8'(f), 8'(k), 8'(~k), 8'(k * 7 + f)};
  endfunction

  // ---------------------------------------------------------------------------
  // AXI4-Lite slave. Decisions are made on the falling edge for the next
  // rising edge, so a handshake is known when ready is raised.
  // ---------------------------------------------------------------------------
  bit          aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, aw_seen = 1'b0;
  int          aw_wait = 0;
  logic [12:0] aw_first, cur_addr;
  logic [31:0] cur_data;

  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; aw_seen = 1'b0; aw_wait = 0;
    end else begin
      m_axi_awready = 1'b0;
      if (m_axi_awvalid && !aw_got) begin
        if (!aw_seen) begin
          aw_seen  = 1'b1;
          aw_first = m_axi_awaddr;
        end
        if (aw_wait >= aw_lat) begin
          if (aw_wait > 0) check("aw_addr_stable", 32'(m_axi_awaddr), 32'(aw_first));
          m_axi_awready = 1'b1;
          aw_got   = 1'b1;
          aw_seen  = 1'b0;
          aw_wait  = 0;
          cur_addr = m_axi_awaddr;
        end else begin
          aw_wait++;
        end
      end

      m_axi_wready = w_early ? !w_got : (m_axi_wvalid && !w_got);
      if (m_axi_wvalid && m_axi_wready) begin
        w_got    = 1'b1;
        cur_data = m_axi_wdata;
        check("wstrb", 32'(m_axi_wstrb), 32'hF);
      end

      if (m_axi_bvalid) begin
        m_axi_bvalid = 1'b0;
      end else if (m_axi_bready && aw_got && w_got) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (berr_en && cur_addr == berr_addr) ? 2'b10 : 2'b00;
        aw_got = 1'b0;
        w_got  = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(cur_addr), 32'h1FFF);
        end else begin
          t = exp_q.pop_front();
          check("wr_kind", 32'(t.is_read), 32'h0);
          check("wr_addr", 32'(cur_addr), 32'(t.addr));
          check("wr_data", cur_data, t.data);
        end
      end

      m_axi_arready = 1'b0;
      if (m_axi_arvalid && !ar_got) begin
        m_axi_arready = 1'b1;
        ar_got = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_read", 32'(m_axi_araddr), 32'h1FFF);
        end else begin
          t = exp_q.pop_front();
          check("rd_kind", 32'(t.is_read), 32'h1);
          check("rd_addr", 32'(m_axi_araddr), 32'(t.addr));
        end
      end

      if (m_axi_rvalid) begin
        m_axi_rvalid = 1'b0;
      end else if (m_axi_rready && ar_got) begin
        m_axi_rvalid = 1'b1;
        m_axi_rresp  = 2'b00;
        // Upper bits are noise; only bit 0 carries the busy flag.
        m_axi_rdata  = {16'hDEAD, 15'h0, (poll_q.size() > 0) ? poll_q.pop_front() : 1'b1};
        ar_got = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cyc++;
    if (m_axi_awvalid) aw_cyc++;
    if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready))
      overlap++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic expect_writes(input int len, input int f, input int nw);
    for (int k = 0; k < nw; k++) exp_q.push_back({1'b0, 13'(4 * k), word_of(f, k)});
    if (nw == (len + 3) / 4) begin
      exp_q.push_back({1'b0, LEN_ADDR, 32'(len)});
      exp_q.push_back({1'b0, CTRL_ADDR, 32'h1});
    end
  endtask

  task automatic expect_polls(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({1'b1, CTRL_ADDR, 32'h0});
  endtask

  task automatic send_cmd(input int len);
    int g;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1;
    cmd_len   = 11'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int f, input int n);
    int k, g;
    k = 0;
    g = 0;
    while (k < n && !err && g < 8 * n + 100) begin
      s_valid = 1'b1;
      s_data  = word_of(f, k);
      if (s_ready) k++;
      @(negedge clk);
      g++;
    end
    s_valid = 1'b0;
    check("feed_stall", 32'(g >= 8 * n + 100), 32'h0);
  endtask

  task automatic wait_end();
    int g;
    g = 0;
    while (!(done || err) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("end_seen", 32'(done || err), 32'h1);
  endtask

  // Full frame; the control register reads busy `ones` times, then idle.
  task automatic run_ok(input int len, input int f, input int ones);
    int nw;
    nw = (len + 3) / 4;
    expect_writes(len, f, nw);
    expect_polls(ones + 1);
    for (int k = 0; k < ones; k++) poll_q.push_back(1'b1);
    poll_q.push_back(1'b0);
    send_cmd(len);
    check("busy_after_cmd", 32'(busy), 32'h1);
    feed(f, nw);
    wait_end();
    check("done", 32'(done), 32'h1);
    check("no_err_at_done", 32'(err), 32'h0);
    check("busy_at_done", 32'(busy), 32'h0);
    check("err_code_ok", 32'(err_code), 32'h0);
    @(negedge clk);
    check("done_width", 32'(done), 32'h0);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic bad_len(input int len);
    int v0;
    v0 = valid_cyc;
    send_cmd(len);
    check("badlen_err", 32'(err), 32'h1);
    check("badlen_code", 32'(err_code), 32'h1);
    check("badlen_busy", 32'(busy), 32'h0);
    check("badlen_s_ready", 32'(s_ready), 32'h0);
    @(negedge clk);
    check("badlen_err_width", 32'(err), 32'h0);
    check("badlen_cmd_ready", 32'(cmd_ready), 32'h1);
    check("badlen_no_axi", 32'(valid_cyc - v0), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int a0, d0, e0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pulses", 32'({done, err}), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);
    check("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
    check("rst_awaddr", 32'(m_axi_awaddr), 32'h0);
    check("rst_wdata", m_axi_wdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'h1);

    run_ok(60, 1, 2);     // 15 words, polls 1,1,0
    run_ok(61, 2, 0);     // 16 words, last at 0x03C
    run_ok(1, 3, 0);      // shortest legal frame
    bad_len(0);
    bad_len(1515);
    run_ok(1514, 4, 1);   // longest legal frame

    // Write error on the third buffer word.
    berr_en   = 1'b1;
    berr_addr = 13'h008;
    expect_writes(64, 5, 3);
    send_cmd(64);
    feed(5, 16);
    wait_end();
    check("bresp_err", 32'(err), 32'h1);
    check("bresp_code", 32'(err_code), 32'h2);
    check("bresp_no_done", 32'(done), 32'h0);
    check("bresp_busy", 32'(busy), 32'h0);
    berr_en = 1'b0;
    a0 = aw_cyc;
    repeat (5) @(negedge clk);
    check("bresp_no_more_aw", 32'(aw_cyc - a0), 32'h0);
    check("err_code_held", 32'(err_code), 32'h2);
    check("bresp_queue", 32'(exp_q.size()), 32'h0);
    run_ok(64, 6, 0);

    // Control register never clears: exactly TIMEOUT reads, then timeout.
    expect_writes(8, 7, 2);
    expect_polls(TIMEOUT);
    send_cmd(8);
    feed(7, 2);
    wait_end();
    check("tmo_err", 32'(err), 32'h1);
    check("tmo_code", 32'(err_code), 32'h3);
    repeat (4) @(negedge clk);
    check("tmo_queue", 32'(exp_q.size()), 32'h0);

    // AW/W skew, then asynchronous reset while the 5th word is in flight.
    aw_lat  = 3;
    w_early = 1'b1;
    expect_writes(40, 8, 5);
    d0 = done_cnt;
    e0 = err_cnt;
    send_cmd(40);
    feed(8, 5);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 32'h0);
    check("arst_ready", 32'({cmd_ready, s_ready}), 32'h0);
    check("arst_awaddr", 32'(m_axi_awaddr), 32'h0);
    check("arst_wdata", m_axi_wdata, 32'h0);
    check("arst_err_code", 32'(err_code), 32'h0);
    exp_q.delete();
    poll_q.delete();
    repeat (3) @(negedge clk);
    check("arst_no_pulse", 32'({done_cnt - d0, err_cnt - e0}), 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    run_ok(40, 9, 1);

    check("rd_wr_overlap", 32'(overlap), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ethlite_tx_ctrl.md
Name: ethlite_tx_ctrl

Overview:
- AXI4-Lite master that sequences one frame transmission through the AXI Ethernet Lite core's TX ping buffer.
- Accepts a length command and a 32-bit word stream, writes the words into the TX buffer, programs the TX length register, and sets the TX start bit.
- Polls the TX control register until the core clears the start bit, then reports done or error.
- Sits between the packet source logic and the s_axi port of the Ethernet Lite instance inside axi_eth.

Parameters:
- P_AXI_ADDR_WIDTH, 13, AXI address width.
- P_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- P_TX_BUF_ADDR, 13'h0000, TX ping buffer base address.
- P_TX_LEN_ADDR, 13'h07F4, TX length register address.
- P_TX_CTRL_ADDR, 13'h07FC, TX control register address; bit0 is start/busy.
- P_MAX_LEN, 1514, maximum frame length in bytes, excluding FCS.
- P_TIMEOUT, 65535, maximum number of poll reads before timeout.

Ports:
- clk  in  1  System clock; same clock as s_axi_aclk.
- rst  in  1  Asynchronous, active-low reset.
- cmd_valid  in  1  Frame command valid.
- cmd_ready  out  1  Command accepted.
- cmd_len  in  11  Frame length in bytes.
- s_valid  in  1  Data word valid.
- s_ready  out  1  Data word accepted.
- s_data  in  32  Frame bytes, little-endian; byte 0 is in bits [7:0].
- busy  out  1  High from command accept until done/err.
- done  out  1  One-cycle pulse on successful completion.
- err  out  1  One-cycle pulse on failure.
- err_code  out  2  Failure cause: 1 = bad length, 2 = AXI response error, 3 = timeout. Held until the next command.
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  Standard AXI4-Lite master channels (awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready).

Behaviour:
- Reset values: all valid/ready outputs, busy, done, err = 0; err_code = 0; addresses and wdata = 0; state = IDLE.
- Reset is asynchronous. Reset asserted mid-frame aborts immediately: no completion, and no done or err pulse.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch len and compute words = (len+3)>>2 as a 10-bit value.
  - If len == 0 or len > P_MAX_LEN: pulse err with err_code = 1 the next cycle and stay in IDLE. The AXI bus is untouched.
  - Otherwise set busy, word index i = 0, and go to GET.
- GET:
  - s_ready = 1.
  - On s_valid, latch s_data into wdata, set awaddr = P_TX_BUF_ADDR + 4*i, and go to WR.
  - s_ready is 0 in every other state.
- WR:
  - Assert awvalid and wvalid together, wstrb = 4'hF.
  - Deassert each valid independently on its own handshake. Hold awaddr and wdata stable while the corresponding valid is high.
  - When both handshakes are done, go to RESP.
- RESP:
  - bready = 1. On bvalid, a nonzero bresp goes to ERR with err_code = 2.
  - Otherwise, route by phase:
    - Data phase, i+1 < words: i++ and go to GET.
    - Last data word: write the length register, with wdata = zero-extended len, then go to WR.
    - After the length write: write the control register with wdata = 32'h1, then go to WR.
    - After the control write: go to POLL_AR with poll count = 0.
- POLL_AR: arvalid = 1, araddr = P_TX_CTRL_ADDR. On arready, go to POLL_R.
- POLL_R:
  - rready = 1. On rvalid:
    - rresp != 0 goes to ERR with err_code = 2.
    - rdata[0] == 0 goes to DONE.
    - Otherwise, if poll count == P_TIMEOUT-1, go to ERR with err_code = 3; else increment the count and go to POLL_AR.
- DONE: pulse done for 1 cycle, clear busy, return to IDLE.
- ERR: pulse err for 1 cycle, clear busy, return to IDLE.
- One outstanding AXI transaction at a time. Read and write channels are never active together.
- arvalid and awvalid, once raised, are never dropped before their handshake.
- Unused trailing bytes of the last word are written as supplied; the core ignores them per the length register.
- Latency: with zero-wait AXI, each word costs GET + WR + RESP = 3 cycles, and each poll costs 2 cycles.

Test Plan:
- cmd_len = 60, AXI slave always ready, control reads return 1, 1, then 0:
  - Expect 15 buffer writes at 0x000 through 0x038 with data in order.
  - Then a write of 60 to 0x7F4 and a write of 1 to 0x7FC.
  - Then 3 reads of 0x7FC, then a done pulse; busy falls on the same cycle.
- cmd_len = 61:
  - Expect 16 buffer writes, the last at 0x03C, and a length write of 61.
- cmd_len = 0, and separately cmd_len = 1515:
  - Expect an err pulse with err_code = 1, no AXI valid asserted, and cmd_ready back to 1 on the next cycle.
- Slave returns bresp = 2'b10 on the 3rd buffer write:
  - Expect an err pulse with err_code = 2 and no further AW issued.
  - A new cmd_len = 64 afterwards completes normally.
- Control reads always return 1, with P_TIMEOUT = 4:
  - Expect exactly 4 reads of 0x7FC, then err with err_code = 3.
- Randomised AW/W ready skew (awready 3 cycles late, wready early), plus rst pulled low in the middle of the 5th word:
  - Expect awaddr and wdata stable while valid; all outputs at reset values asynchronously; no done or err pulse.
  - A new frame after reset completes normally.
